// File: rtl/quote_tx_pkg.sv
// Shared message constants, FSM state encoding and quote record for the order tx path.
package quote_tx_pkg;

  localparam int unsigned QUOTE_W = 32;

  localparam logic [7:0] MSG_NEW      = 8'h01;
  localparam logic [7:0] MSG_CXL_REPL = 8'h02;
  localparam logic [7:0] SIDE_BID     = 8'h00;
  localparam logic [7:0] SIDE_ASK     = 8'h01;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PX, ST_QTY} tx_state_t;

  typedef struct packed {
    logic [QUOTE_W-1:0] buy;
    logic [QUOTE_W-1:0] ask;
  } quote_t;

endpackage

// File: rtl/order_id_gen.sv
// Order-id counter: starts at 1, advances on i_inc, wraps from all-ones back to 1.
module order_id_gen #(
  parameter int unsigned ID_WIDTH = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_inc,
  output logic [ID_WIDTH-1:0] o_id
);

  logic [ID_WIDTH-1:0] id_q, id_d;

  // Id 0 is reserved, so the wrap skips it.
  always_comb begin
    id_d = id_q;
    if (i_inc) begin
      id_d = (id_q == '1) ? ID_WIDTH'(1) : id_q + ID_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      id_q <= ID_WIDTH'(1);
    end else begin
      id_q <= id_d;
    end
  end

  assign o_id = id_q;

endmodule

// File: rtl/quote_order_tx.sv
// Serialises bid/ask quotes into 3-word order messages (HDR, PX, QTY) on a valid/ready
// stream, sending only sides whose price moved; a single pending slot keeps the newest quote.
module quote_order_tx
  import quote_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = QUOTE_W,
  parameter int unsigned ID_WIDTH   = 16,
  parameter int unsigned ORDER_QTY  = 100
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_buy_price,
  input  logic [DATA_WIDTH-1:0] i_ask_price,
  input  logic                  i_data_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_word_valid,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_overwrite
);

  tx_state_t             state_q, state_d;
  quote_t                pend_q, pend_d, tgt_q, tgt_d, src;
  logic                  pend_valid_q, pend_valid_d;
  logic                  need_ask_q, need_ask_d;
  logic                  side_ask_q, side_ask_d;
  logic [DATA_WIDTH-1:0] live_bid_q, live_bid_d, live_ask_q, live_ask_d;
  logic                  overwrite_q, overwrite_d;
  logic                  need_bid_c, need_ask_c;
  logic [ID_WIDTH-1:0]   id;
  logic                  id_inc;
  logic [DATA_WIDTH-1:0] cur_price, cur_live;
  logic [7:0]            msg_type, msg_side;

  assign id_inc = (state_q == ST_HDR) && i_ready;

  order_id_gen #(
    .ID_WIDTH(ID_WIDTH)
  ) u_order_id_gen (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_inc  (id_inc),
    .o_id   (id)
  );

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    tgt_d        = tgt_q;
    need_ask_d   = need_ask_q;
    side_ask_d   = side_ask_q;
    live_bid_d   = live_bid_q;
    live_ask_d   = live_ask_q;
    overwrite_d  = 1'b0;

    src.buy = i_data_valid ? i_buy_price : pend_q.buy;
    src.ask = i_data_valid ? i_ask_price : pend_q.ask;
    need_bid_c = (src.buy != '0) && (src.buy != live_bid_q);
    need_ask_c = (src.ask != '0) && (src.ask != live_ask_q);

    unique case (state_q)
      ST_IDLE: begin
        if (i_data_valid || pend_valid_q) begin
          pend_valid_d = 1'b0;
          overwrite_d  = i_data_valid && pend_valid_q;
          if (need_bid_c || need_ask_c) begin
            tgt_d      = src;
            need_ask_d = need_ask_c;
            side_ask_d = !need_bid_c;
            state_d    = ST_HDR;
          end
        end
      end
      ST_HDR: if (i_ready) state_d = ST_PX;
      ST_PX:  if (i_ready) state_d = ST_QTY;
      ST_QTY: begin
        if (i_ready) begin
          if (side_ask_q) live_ask_d = tgt_q.ask;
          else            live_bid_d = tgt_q.buy;
          if (!side_ask_q && need_ask_q) begin
            side_ask_d = 1'b1;
            state_d    = ST_HDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Quotes arriving mid-message (including on the final QTY) park in the pending slot.
    if ((state_q != ST_IDLE) && i_data_valid) begin
      pend_d.buy   = i_buy_price;
      pend_d.ask   = i_ask_price;
      pend_valid_d = 1'b1;
      overwrite_d  = pend_valid_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      tgt_q        <= '0;
      need_ask_q   <= 1'b0;
      side_ask_q   <= 1'b0;
      live_bid_q   <= '0;
      live_ask_q   <= '0;
      overwrite_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      tgt_q        <= tgt_d;
      need_ask_q   <= need_ask_d;
      side_ask_q   <= side_ask_d;
      live_bid_q   <= live_bid_d;
      live_ask_q   <= live_ask_d;
      overwrite_q  <= overwrite_d;
    end
  end

  // Words derive only from latched state, so they hold steady under backpressure.
  always_comb begin
    cur_price = side_ask_q ? tgt_q.ask : tgt_q.buy;
    cur_live  = side_ask_q ? live_ask_q : live_bid_q;
    msg_type  = (cur_live == '0) ? MSG_NEW : MSG_CXL_REPL;
    msg_side  = side_ask_q ? SIDE_ASK : SIDE_BID;
    o_word    = '0;
    unique case (state_q)
      ST_HDR:  o_word = DATA_WIDTH'({msg_type, msg_side, 16'(id)});
      ST_PX:   o_word = cur_price;
      ST_QTY:  o_word = DATA_WIDTH'(ORDER_QTY);
      default: o_word = '0;
    endcase
  end

  assign o_word_valid = (state_q != ST_IDLE);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_last       = (state_q == ST_QTY);
  assign o_overwrite  = overwrite_q;

endmodule

// File: tb/tb_quote_order_tx.sv
// Directed and randomised checks of quote_order_tx against a message-queue reference model.
module tb_quote_order_tx;

  localparam int unsigned ID_W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] buy_price = '0, ask_price = '0;
  logic        data_valid = 1'b0, ready = 1'b0;
  logic [31:0] word;
  logic        word_valid, last, busy, overwrite;

  quote_order_tx #(
    .DATA_WIDTH(32),
    .ID_WIDTH  (ID_W),
    .ORDER_QTY (100)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_buy_price (buy_price),
    .i_ask_price (ask_price),
    .i_data_valid(data_valid),
    .i_ready     (ready),
    .o_word      (word),
    .o_word_valid(word_valid),
    .o_last      (last),
    .o_busy      (busy),
    .o_overwrite (overwrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    bit          lst;
    bit          ask;
    logic [31:0] px;
  } mw_t;

  // Reference model: words still owed on the link, plus link-independent quote state.
  mw_t         exp_q[$];
  logic [31:0] wlog[$];
  logic [31:0] m_live_bid, m_live_ask, m_pend_buy, m_pend_ask;
  bit          m_pend_v, m_ov;
  int unsigned m_next_id;
  int          tests = 0, fails = 0, ov_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_live_bid = 0; m_live_ask = 0; m_pend_v = 0; m_pend_buy = 0; m_pend_ask = 0;
    m_ov = 0; m_next_id = 1;
  endtask

  task automatic push_msg(input bit ask, input logic [31:0] px);
    logic [31:0] live;
    logic [7:0]  typ;
    live = ask ? m_live_ask : m_live_bid;
    typ  = (live == 0) ? 8'h01 : 8'h02;
    exp_q.push_back('{{typ, (ask ? 8'h01 : 8'h00), 16'(m_next_id)}, 1'b0, ask, px});
    exp_q.push_back('{px, 1'b0, ask, px});
    exp_q.push_back('{32'd100, 1'b1, ask, px});
    m_next_id = (m_next_id == (1 << ID_W) - 1) ? 1 : m_next_id + 1;
  endtask

  // Advance the model across the coming rising edge, given the inputs now driven.
  task automatic model_step();
    bit          idle;
    mw_t         m;
    logic [31:0] sb, sa;
    idle = (exp_q.size() == 0);
    m_ov = 0;
    if (!idle && ready) begin
      m = exp_q.pop_front();
      wlog.push_back(m.w);
      if (m.lst) begin
        if (m.ask) m_live_ask = m.px;
        else       m_live_bid = m.px;
      end
    end
    if (idle) begin
      if (data_valid || m_pend_v) begin
        sb = data_valid ? buy_price : m_pend_buy;
        sa = data_valid ? ask_price : m_pend_ask;
        m_ov = data_valid && m_pend_v;
        m_pend_v = 0;
        if (sb != 0 && sb != m_live_bid) push_msg(1'b0, sb);
        if (sa != 0 && sa != m_live_ask) push_msg(1'b1, sa);
      end
    end else if (data_valid) begin
      m_ov = m_pend_v;
      m_pend_v = 1; m_pend_buy = buy_price; m_pend_ask = ask_price;
    end
  endtask

  task automatic check_all();
    bit v;
    v = (exp_q.size() != 0);
    chk("word_valid", {31'd0, word_valid}, {31'd0, v});
    chk("busy", {31'd0, busy}, {31'd0, v});
    chk("overwrite", {31'd0, overwrite}, {31'd0, m_ov});
    if (overwrite) ov_cnt++;
    if (v) begin
      chk("word", word, exp_q[0].w);
      chk("last", {31'd0, last}, {31'd0, exp_q[0].lst});
    end else begin
      chk("word_idle", word, 32'd0);
      chk("last_idle", {31'd0, last}, 32'd0);
    end
  endtask

  task automatic cycle(input bit dv, input logic [31:0] b, input logic [31:0] a, input bit rdy);
    data_valid = dv; buy_price = b; ask_price = a; ready = rdy;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic chk_std_pair(input string tag);
    logic [31:0] want[6];
    want = '{32'h01000001, 32'd100, 32'd100, 32'h01010002, 32'd102, 32'd100};
    chk({tag, "_len"}, wlog.size(), 32'd6);
    if (wlog.size() == 6)
      for (int i = 0; i < 6; i++) chk(tag, wlog[i], want[i]);
  endtask

  initial begin
    logic [31:0] hdr;
    int unsigned rb, ra;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // 1: both sides NEW, back to back.
    wlog.delete();
    cycle(1'b1, 32'd100, 32'd102, 1'b1);
    drain(7);
    chk_std_pair("t1_words");

    // 2: repeated quote absorbed, then ask-only cancel/replace.
    wlog.delete();
    cycle(1'b1, 32'd100, 32'd102, 1'b1);
    chk("t2_no_busy", {31'd0, busy}, 32'd0);
    drain(2);
    chk("t2_no_words", wlog.size(), 32'd0);
    cycle(1'b1, 32'd100, 32'd103, 1'b1);
    drain(4);
    chk("t2_len", wlog.size(), 32'd3);
    if (wlog.size() == 3) begin
      chk("t2_hdr", wlog[0], 32'h02010003);
      chk("t2_px", wlog[1], 32'd103);
    end

    // 3: backpressure while PX is presented.
    wlog.delete();
    cycle(1'b1, 32'd105, 32'd106, 1'b1);
    cycle(1'b0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'd0, 32'd0, 1'b0);
      chk("t3_px_hold", word, 32'd105);
    end
    drain(8);
    chk("t3_len", wlog.size(), 32'd6);
    if (wlog.size() == 6) chk("t3_px", wlog[1], 32'd105);

    // 4: two quotes while busy; newest wins.
    wlog.delete();
    ov_cnt = 0;
    cycle(1'b1, 32'd107, 32'd108, 1'b1);
    cycle(1'b1, 32'd110, 32'd111, 1'b1);
    cycle(1'b1, 32'd112, 32'd113, 1'b1);
    drain(16);
    chk("t4_ov_pulses", ov_cnt, 32'd1);
    chk("t4_len", wlog.size(), 32'd12);
    if (wlog.size() == 12) begin
      chk("t4_bid_px", wlog[7], 32'd112);
      chk("t4_ask_px", wlog[10], 32'd113);
    end

    // 5: zero bid never sent and leaves live bid alone.
    wlog.delete();
    cycle(1'b1, 32'd0, 32'd120, 1'b1);
    drain(6);
    chk("t5_len", wlog.size(), 32'd3);
    if (wlog.size() == 3) begin
      hdr = wlog[0];
      chk("t5_side", {24'd0, hdr[23:16]}, 32'd1);
      chk("t5_px", wlog[1], 32'd120);
    end
    cycle(1'b1, 32'd112, 32'd120, 1'b1);
    drain(4);
    chk("t5_bid_kept", wlog.size(), 32'd3);

    // Random traffic; small price set forces repeats, zeros and id wraps.
    for (int i = 0; i < 800; i++) begin
      rb = $urandom_range(0, 4);
      ra = $urandom_range(0, 4);
      cycle(($urandom_range(0, 2) == 0), (rb == 0) ? 32'd0 : 32'(100 + rb),
            (ra == 0) ? 32'd0 : 32'(100 + ra), ($urandom_range(0, 3) != 0));
    end
    drain(20);

    // 6: reset mid-message.
    cycle(1'b1, 32'd130, 32'd131, 1'b1);
    chk("t6_pre_valid", {31'd0, word_valid}, 32'd1);
    data_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, word_valid}, 32'd0);
    chk("t6_rst_word", word, 32'd0);
    chk("t6_rst_last", {31'd0, last}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_ovw", {31'd0, overwrite}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    wlog.delete();
    cycle(1'b1, 32'd100, 32'd102, 1'b1);
    drain(7);
    chk_std_pair("t6_words");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
